// File: rtl/psum_spike_accumulator.sv
// Sums ROWS partial sums per output pixel, integrates them into a per-pixel membrane
// potential and emits one spike/membrane packet per pixel. Optional leak: PSUM_LEAK_EN.
module psum_spike_accumulator #(
    parameter int PSUM_W  = 12,
    parameter int ACC_W   = 16,
    parameter int ROWS    = 3,
    parameter int NUM_OUT = 25,
    parameter int THRESH  = 64,
    parameter int LEAK    = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clear,
    input  logic                       psum_valid,
    output logic                       psum_ready,
    input  logic [PSUM_W-1:0]          psum_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       out_spike,
    output logic [$clog2(NUM_OUT)-1:0] out_addr,
    output logic [ACC_W-1:0]           out_mem,
    output logic                       ts_done
);
    localparam int ADDR_W = $clog2(NUM_OUT);
    localparam int ROW_W  = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic [ACC_W-1:0] MAX_V    = '1;
    localparam logic [ACC_W-1:0] THRESH_V = ACC_W'(THRESH);
    localparam logic [ACC_W-1:0] LEAK_V   = ACC_W'(LEAK);
`ifdef PSUM_LEAK_EN
    localparam bit LEAK_ON = 1'b1;
`else
    localparam bit LEAK_ON = 1'b0;
`endif

    typedef enum logic [1:0] {ACCUM, UPDATE, EMIT} state_t;

    state_t             state;
    logic [ROW_W-1:0]   row_cnt;
    logic [ADDR_W-1:0]  pix_cnt;
    logic [ACC_W-1:0]   row_sum;
    logic [ACC_W-1:0]   mem [NUM_OUT];

    logic [ACC_W:0]     row_add;
    logic [ACC_W-1:0]   row_sat;
    logic [ACC_W-1:0]   mem_cur;
    logic [ACC_W-1:0]   mem_base;
    logic [ACC_W:0]     n_add;
    logic [ACC_W-1:0]   n_sat;
    logic               spike;
    logic [ACC_W-1:0]   mem_new;

    // Valid/ready: a transfer happens on a rising edge where both are high; a clear
    // cycle never accepts a psum, so ready is withheld during it.
    assign psum_ready = rst_n && !clear && (state == ACCUM);

    always_comb begin
        row_add  = {1'b0, row_sum} + {{(ACC_W + 1 - PSUM_W){1'b0}}, psum_data};
        row_sat  = row_add[ACC_W] ? MAX_V : row_add[ACC_W-1:0];
        mem_cur  = mem[pix_cnt];
        mem_base = mem_cur;
        if (LEAK_ON) begin
            mem_base = (mem_cur >= LEAK_V) ? (mem_cur - LEAK_V) : '0;
        end
        n_add    = {1'b0, mem_base} + {1'b0, row_sum};
        n_sat    = n_add[ACC_W] ? MAX_V : n_add[ACC_W-1:0];
        spike    = (n_sat >= THRESH_V);
        mem_new  = spike ? (n_sat - THRESH_V) : n_sat;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ACCUM;
            row_cnt   <= '0;
            pix_cnt   <= '0;
            row_sum   <= '0;
            for (int i = 0; i < NUM_OUT; i++) mem[i] <= '0;
            out_valid <= 1'b0;
            out_spike <= 1'b0;
            out_addr  <= '0;
            out_mem   <= '0;
            ts_done   <= 1'b0;
        end else if (clear) begin
            // Aborts the pixel in flight, including a packet waiting in EMIT.
            state     <= ACCUM;
            row_cnt   <= '0;
            pix_cnt   <= '0;
            row_sum   <= '0;
            for (int i = 0; i < NUM_OUT; i++) mem[i] <= '0;
            out_valid <= 1'b0;
            ts_done   <= 1'b0;
        end else begin
            ts_done <= 1'b0;
            case (state)
                ACCUM: begin
                    if (psum_valid) begin
                        row_sum <= row_sat;
                        if (row_cnt == ROW_W'(ROWS - 1)) begin
                            row_cnt <= '0;
                            state   <= UPDATE;
                        end else begin
                            row_cnt <= row_cnt + ROW_W'(1);
                        end
                    end
                end
                UPDATE: begin
                    mem[pix_cnt] <= mem_new;
                    out_spike    <= spike;
                    out_addr     <= pix_cnt;
                    out_mem      <= mem_new;
                    out_valid    <= 1'b1;
                    row_sum      <= '0;
                    state        <= EMIT;
                end
                EMIT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= ACCUM;
                        if (pix_cnt == ADDR_W'(NUM_OUT - 1)) begin
                            pix_cnt <= '0;
                            ts_done <= 1'b1;
                        end else begin
                            pix_cnt <= pix_cnt + ADDR_W'(1);
                        end
                    end
                end
                default: state <= ACCUM;
            endcase
        end
    end
endmodule

// File: tb/tb_psum_spike_accumulator.sv
// Self-checking bench for psum_spike_accumulator: two instances (THRESH=64 and THRESH=65535)
// run in lockstep from shared inputs; a behavioural model predicts every packet.
`timescale 1ns/1ps
module tb_psum_spike_accumulator;
    localparam int PSUM_W  = 12;
    localparam int ACC_W   = 16;
    localparam int ROWS    = 3;
    localparam int NUM_OUT = 2;
    localparam int AW      = $clog2(NUM_OUT);
    localparam int PKT_W   = 1 + AW + ACC_W;
    localparam int MAXV    = 65535;
    localparam int LEAK    = 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              clear = 1'b0;
    logic              psum_valid = 1'b0;
    logic [PSUM_W-1:0] psum_data = '0;
    logic              out_ready = 1'b1;
    logic              use_sat = 1'b0;

    logic              a_psum_ready, a_out_valid, a_out_spike, a_ts_done;
    logic [AW-1:0]     a_out_addr;
    logic [ACC_W-1:0]  a_out_mem;
    logic              s_psum_ready, s_out_valid, s_out_spike, s_ts_done;
    logic [AW-1:0]     s_out_addr;
    logic [ACC_W-1:0]  s_out_mem;

    logic              o_ready, o_valid, o_spike, o_ts;
    logic [AW-1:0]     o_addr;
    logic [ACC_W-1:0]  o_mem;

    int tests = 0;
    int fails = 0;

    logic [PKT_W-1:0] exp_q[$];
    int mem_m[NUM_OUT];
    int row_m, rcnt_m, pix_m;
    int thresh_m = 64;

    always #5 clk = ~clk;

    psum_spike_accumulator #(.PSUM_W(PSUM_W), .ACC_W(ACC_W), .ROWS(ROWS), .NUM_OUT(NUM_OUT),
                             .THRESH(64), .LEAK(LEAK)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .psum_valid(psum_valid),
        .psum_ready(a_psum_ready), .psum_data(psum_data), .out_valid(a_out_valid),
        .out_ready(out_ready), .out_spike(a_out_spike), .out_addr(a_out_addr),
        .out_mem(a_out_mem), .ts_done(a_ts_done));

    psum_spike_accumulator #(.PSUM_W(PSUM_W), .ACC_W(ACC_W), .ROWS(ROWS), .NUM_OUT(NUM_OUT),
                             .THRESH(65535), .LEAK(LEAK)) dut_sat (
        .clk(clk), .rst_n(rst_n), .clear(clear), .psum_valid(psum_valid),
        .psum_ready(s_psum_ready), .psum_data(psum_data), .out_valid(s_out_valid),
        .out_ready(out_ready), .out_spike(s_out_spike), .out_addr(s_out_addr),
        .out_mem(s_out_mem), .ts_done(s_ts_done));

    assign o_ready = use_sat ? s_psum_ready : a_psum_ready;
    assign o_valid = use_sat ? s_out_valid  : a_out_valid;
    assign o_spike = use_sat ? s_out_spike  : a_out_spike;
    assign o_addr  = use_sat ? s_out_addr   : a_out_addr;
    assign o_mem   = use_sat ? s_out_mem    : a_out_mem;
    assign o_ts    = use_sat ? s_ts_done    : a_ts_done;

    // ---------------- reference model ----------------
    function automatic void model_clear();
        for (int i = 0; i < NUM_OUT; i++) mem_m[i] = 0;
        row_m = 0; rcnt_m = 0; pix_m = 0;
        exp_q.delete();
    endfunction

    function automatic void model_psum(input int d);
        int n;
        row_m = (row_m + d > MAXV) ? MAXV : row_m + d;
        rcnt_m++;
        if (rcnt_m == ROWS) begin
            n = mem_m[pix_m];
`ifdef PSUM_LEAK_EN
            n = (n > LEAK) ? n - LEAK : 0;
`endif
            n = n + row_m;
            if (n > MAXV) n = MAXV;
            if (n >= thresh_m) begin
                mem_m[pix_m] = n - thresh_m;
                exp_q.push_back({1'b1, AW'(pix_m), ACC_W'(n - thresh_m)});
            end else begin
                mem_m[pix_m] = n;
                exp_q.push_back({1'b0, AW'(pix_m), ACC_W'(n)});
            end
            row_m = 0; rcnt_m = 0;
            pix_m = (pix_m + 1) % NUM_OUT;
        end
    endfunction

    // ---------------- driver tasks ----------------
    task automatic send_psum(input int d);
        int waited = 0;
        @(negedge clk);
        psum_valid = 1'b1;
        psum_data  = PSUM_W'(d);
        while (!o_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!o_ready) begin
            tests++; fails++;
            $display("FAIL send_psum_timeout: psum_ready=%0b required 1", o_ready);
        end else begin
            @(posedge clk);
            model_psum(d);
        end
        #1 psum_valid = 1'b0;
    endtask

    task automatic collect_packet(input int stall, output bit ok, output logic [PKT_W-1:0] pkt);
        ok = 1'b0;
        pkt = '0;
        if (stall > 0) out_ready = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (o_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (ok) begin
            pkt = {o_spike, o_addr, o_mem};
            repeat (stall) @(negedge clk);
            out_ready = 1'b1;
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
    endtask

    task automatic pulse_clear();
        @(negedge clk);
        clear = 1'b1;
        @(posedge clk);
        #1 clear = 1'b0;
        model_clear();
    endtask

    task automatic pixel(input int d0, input int d1, input int d2);
        send_psum(d0); send_psum(d1); send_psum(d2);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        #3;
        tests++;
        if ({o_ready, o_valid, o_spike, o_addr, o_mem, o_ts} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: ready=%0b valid=%0b spike=%0b addr=%0d mem=%0d ts=%0b required all 0",
                     o_ready, o_valid, o_spike, o_addr, o_mem, o_ts);
        end
        #9 rst_n = 1'b1;
        model_clear();
        @(negedge clk);
        tests++;
        if (o_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_ready_after: psum_ready=%0b required 1", o_ready);
        end
    endtask

    task automatic test_first_pixel();
        logic [PKT_W-1:0] exp;
        pixel(10, 20, 30);
        tests++;
        if (o_valid !== 1'b0) begin
            fails++; $display("FAIL latency_early: out_valid=%0b required 0", o_valid);
        end
        @(posedge clk); #1;
        exp = exp_q.pop_front();
        tests++;
        if (o_valid !== 1'b1 || {o_spike, o_addr, o_mem} !== exp) begin
            fails++;
            $display("FAIL pixel0_packet: valid=%0b pkt=%h required valid=1 pkt=%h", o_valid, {o_spike, o_addr, o_mem}, exp);
        end
        tests++;
        if (o_mem !== 16'd60 || o_spike !== 1'b0 || o_addr !== '0) begin
            fails++; $display("FAIL pixel0_literal: mem=%0d spike=%0b required mem=60 spike=0", o_mem, o_spike);
        end
        @(posedge clk); #1;
        tests++;
        if (o_valid !== 1'b0) begin
            fails++; $display("FAIL pixel0_handshake: out_valid=%0b required 0", o_valid);
        end
    endtask

    task automatic test_spike_and_ts();
        bit ok;
        logic [PKT_W-1:0] pkt, exp;
        pixel(40, 20, 4);
        collect_packet(0, ok, pkt);
        exp = exp_q.pop_front();
        tests++;
        if (!ok || pkt !== exp || pkt !== {1'b1, AW'(1), 16'd0}) begin
            fails++; $display("FAIL pixel1_spike: ok=%0b pkt=%h required %h", ok, pkt, exp);
        end
        tests++;
        if (o_ts !== 1'b1) begin
            fails++; $display("FAIL ts_done_high: ts_done=%0b required 1", o_ts);
        end
        @(posedge clk); #1;
        tests++;
        if (o_ts !== 1'b0) begin
            fails++; $display("FAIL ts_done_pulse: ts_done=%0b required 0", o_ts);
        end
        pixel(4, 0, 0);
        collect_packet(0, ok, pkt);
        exp = exp_q.pop_front();
        tests++;
        if (!ok || pkt !== exp || pkt !== {1'b1, AW'(0), 16'd0}) begin
            fails++; $display("FAIL pixel0_wrap_spike: ok=%0b pkt=%h required %h", ok, pkt, exp);
        end
    endtask

    task automatic test_back_pressure();
        logic [PKT_W-1:0] pkt0, exp;
        bit seen = 1'b0;
        out_ready = 1'b0;
        pixel($urandom_range(0, 40), $urandom_range(0, 40), $urandom_range(0, 40));
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = o_valid;
        end
        tests++;
        if (!seen) begin
            fails++; $display("FAIL bp_valid_timeout: out_valid=%0b required 1", o_valid);
        end
        pkt0 = {o_spike, o_addr, o_mem};
        psum_valid = 1'b1;
        psum_data  = 12'd5;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            tests++;
            if (o_valid !== 1'b1 || {o_spike, o_addr, o_mem} !== pkt0 || o_ready !== 1'b0) begin
                fails++;
                $display("FAIL bp_hold: valid=%0b pkt=%h ready=%0b required valid=1 pkt=%h ready=0",
                         o_valid, {o_spike, o_addr, o_mem}, o_ready, pkt0);
            end
        end
        @(negedge clk);
        psum_valid = 1'b0;
        out_ready  = 1'b1;
        @(posedge clk); #1;
        exp = exp_q.pop_front();
        tests++;
        if (o_valid !== 1'b0 || pkt0 !== exp) begin
            fails++; $display("FAIL bp_release: valid=%0b pkt=%h required valid=0 pkt=%h", o_valid, pkt0, exp);
        end
        @(posedge clk); #1;
        tests++;
        if (o_valid !== 1'b0) begin
            fails++; $display("FAIL bp_single_transfer: out_valid=%0b required 0", o_valid);
        end
    endtask

    task automatic test_random();
        bit ok;
        logic [PKT_W-1:0] pkt, exp;
        for (int p = 0; p < 30; p++) begin
            for (int r = 0; r < ROWS; r++) begin
                repeat ($urandom_range(0, 2)) @(negedge clk);
                send_psum(($urandom_range(0, 3) == 0) ? $urandom_range(0, 4095) : $urandom_range(0, 40));
            end
            collect_packet($urandom_range(0, 3), ok, pkt);
            tests++;
            if (!ok || exp_q.size() == 0) begin
                fails++; $display("FAIL rand_no_packet: ok=%0b queued=%0d required ok=1 queued>0", ok, exp_q.size());
            end else begin
                exp = exp_q.pop_front();
                if (pkt !== exp) begin
                    fails++; $display("FAIL rand_packet %0d: pkt=%h required %h", p, pkt, exp);
                end
                tests++;
                if (o_ts !== (exp[ACC_W +: AW] == AW'(NUM_OUT - 1))) begin
                    fails++; $display("FAIL rand_ts_done %0d: ts_done=%0b addr=%0d", p, o_ts, exp[ACC_W +: AW]);
                end
            end
        end
    endtask

    task automatic test_saturation();
        bit ok;
        logic [PKT_W-1:0] pkt, exp;
        use_sat  = 1'b1;
        thresh_m = 65535;
        pulse_clear();
        for (int k = 0; k < 12; k++) begin
            pixel(4095, 4095, 4095);
            collect_packet(0, ok, pkt);
            exp = exp_q.pop_front();
            tests++;
            if (!ok || pkt !== exp) begin
                fails++; $display("FAIL sat_packet %0d: ok=%0b pkt=%h required %h", k, ok, pkt, exp);
            end
            if (k == 10) begin
                tests++;
                if (pkt !== {1'b1, AW'(0), 16'd0}) begin
                    fails++; $display("FAIL sat_clamp_spike: pkt=%h required spike=1 addr=0 mem=0", pkt);
                end
            end
        end
        use_sat  = 1'b0;
        thresh_m = 64;
        pulse_clear();
    endtask

    task automatic test_clear();
        bit ok;
        logic [PKT_W-1:0] pkt, exp;
        pulse_clear();
        send_psum(10); send_psum(10);
        @(negedge clk);
        clear = 1'b1; psum_valid = 1'b1; psum_data = 12'd99;
        #1;
        tests++;
        if (o_ready !== 1'b0) begin
            fails++; $display("FAIL clear_blocks_psum: psum_ready=%0b required 0", o_ready);
        end
        @(posedge clk);
        #1 clear = 1'b0; psum_valid = 1'b0;
        model_clear();
        pixel(1, 2, 3);
        collect_packet(0, ok, pkt);
        exp = exp_q.pop_front();
        tests++;
        if (!ok || pkt !== exp || pkt !== {1'b0, AW'(0), 16'd6}) begin
            fails++; $display("FAIL clear_then_pixel: ok=%0b pkt=%h required %h", ok, pkt, exp);
        end
        pixel(5, 5, 5);
        @(posedge clk); #1;
        tests++;
        if (o_valid !== 1'b1) begin
            fails++; $display("FAIL clear_emit_setup: out_valid=%0b required 1", o_valid);
        end
        pulse_clear();
        tests++;
        if (o_valid !== 1'b0 || o_ts !== 1'b0) begin
            fails++; $display("FAIL clear_drops_packet: valid=%0b ts_done=%0b required 0 0", o_valid, o_ts);
        end
        pixel(7, 0, 0);
        collect_packet(0, ok, pkt);
        exp = exp_q.pop_front();
        tests++;
        if (!ok || pkt !== exp || pkt !== {1'b0, AW'(0), 16'd7}) begin
            fails++; $display("FAIL clear_restart: ok=%0b pkt=%h required %h", ok, pkt, exp);
        end
    endtask

    task automatic test_async_reset();
        bit ok;
        logic [PKT_W-1:0] pkt, exp;
        send_psum(20); send_psum(30);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #0.5;
        tests++;
        if (o_ready !== 1'b0 || o_valid !== 1'b0) begin
            fails++; $display("FAIL async_reset: psum_ready=%0b out_valid=%0b required 0 0", o_ready, o_valid);
        end
        #0.5 rst_n = 1'b1;
        model_clear();
        pixel(1, 1, 1);
        collect_packet(0, ok, pkt);
        exp = exp_q.pop_front();
        tests++;
        if (!ok || pkt !== exp || pkt !== {1'b0, AW'(0), 16'd3}) begin
            fails++; $display("FAIL reset_restart: ok=%0b pkt=%h required %h", ok, pkt, exp);
        end
    endtask

    task automatic test_leak();
        bit ok;
        logic [PKT_W-1:0] pkt, exp;
        logic [ACC_W-1:0] lit;
`ifdef PSUM_LEAK_EN
        lit = 16'd59;
`else
        lit = 16'd60;
`endif
        pulse_clear();
        pixel(10, 20, 30);
        collect_packet(0, ok, pkt);
        void'(exp_q.pop_front());
        pixel(0, 0, 0);
        collect_packet(0, ok, pkt);
        void'(exp_q.pop_front());
        pixel(0, 0, 0);
        collect_packet(0, ok, pkt);
        exp = exp_q.pop_front();
        tests++;
        if (!ok || pkt !== exp || pkt[ACC_W-1:0] !== lit) begin
            fails++; $display("FAIL leak_pixel0: ok=%0b pkt=%h required %h mem=%0d", ok, pkt, exp, lit);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_first_pixel();
        test_spike_and_ts();
        test_back_pressure();
        test_random();
        test_saturation();
        test_clear();
        test_async_reset();
        test_leak();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
